uart_impl_top: RTL and testbench

Board-level top that receives 8N1 serial bytes on `uart_rxd` and shows one nibble of the last good byte on four green LEDs. Slide switches provide reset and display selection. The block contains one UART receiver sub-module plus a small display register. It is the whole FPGA design for this exercise; there is no transmit path.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx.sv | 107 ++++++++++
 rtl/uart_impl_top.sv | 72 +++++++
 tb/tb_uart_impl_top.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive demo: receiver FSM states,
// bit-period helper and slide-switch bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned SW_RESETN = 0;
  localparam int unsigned SW_NIB    = 1;
  localparam int unsigned SW_CNT    = 2;
  localparam int unsigned SW_STAT   = 3;

  // Clock cycles per serial bit, truncating.
  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, start/data/stop FSM,
// bit-period counter and LSB-first shift register.
// Ports:
//   clk      - system clock
//   resetn   - synchronous active-low reset
//   rxd      - asynchronous serial input, idles high
//   rx_data  - received byte (valid when rx_valid pulses)
//   rx_valid - 1-cycle pulse, byte received with good stop bit
//   rx_ferr  - 1-cycle pulse, stop bit sampled low (byte discarded)
//   busy     - FSM is not in IDLE
//   rxd_sync - synchronized serial line
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE = 9600,
  parameter int unsigned CLK_HZ   = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       busy,
  output logic       rxd_sync
);

  localparam int unsigned CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned HALF  = (CPB / 2 > 0) ? CPB / 2 : 1;
  localparam int unsigned CNT_W = $clog2(CPB + 1);

  rx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       rx_data_n;
  logic             rx_valid_n, rx_ferr_n, busy_n;
  logic             rxd_meta;

  // State and output registers; synchronizer resets to line-idle level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      rx_ferr  <= rx_ferr_n;
      busy     <= busy_n;
    end
  end

  // Next-state logic; sampling happens when the counter reaches its terminal value.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CNT_W'(1);
    bit_idx_n  = bit_idx;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rx_ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxd_sync) state_n = START;
      end
      START: begin
        if (cnt == CNT_W'(HALF - 1)) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          // A line back high at mid-start is a glitch, not a frame.
          state_n   = rxd_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_W'(CPB - 1)) begin
          cnt_n     = '0;
          rx_data_n = {rxd_sync, rx_data[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_W'(CPB - 1)) begin
          cnt_n      = '0;
          rx_valid_n = rxd_sync;
          rx_ferr_n  = !rxd_sync;
          // Returning at mid-stop lets a zero-gap next frame be caught.
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: rtl/uart_impl_top.sv
// Board top: receives 8N1 bytes on uart_rxd and shows a nibble of the last
// good byte, the byte count, or receiver status on four LEDs.
// Ports:
//   clk      - system clock
//   sw_0     - [0] resetn (sync, active-low), [1] 1=low nibble,
//              [2] show byte count, [3] show status
//   led      - registered LED outputs
//   uart_rxd - asynchronous serial input, idles high
module uart_impl_top
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE = 9600,
  parameter int unsigned CLK_HZ   = 50000000
) (
  input  logic       clk,
  input  logic [3:0] sw_0,
  output logic [3:0] led,
  input  logic       uart_rxd
);

  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr, busy, rxd_sync;
  logic [7:0] last_byte, byte_cnt;
  logic       ferr_flag;
  logic [3:0] led_n;

  assign resetn = sw_0[SW_RESETN];

  uart_rx #(
    .BIT_RATE (BIT_RATE),
    .CLK_HZ   (CLK_HZ)
  ) u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .rxd      (uart_rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .busy     (busy),
    .rxd_sync (rxd_sync)
  );

  // Display registers: last good byte, wrapping count, sticky framing error.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_byte <= '0;
      byte_cnt  <= '0;
      ferr_flag <= 1'b0;
      led       <= '0;
    end else begin
      if (rx_valid) begin
        last_byte <= rx_data;
        byte_cnt  <= byte_cnt + 8'd1;
      end
      if (rx_ferr) ferr_flag <= 1'b1;
      led <= led_n;
    end
  end

  // LED source mux: status over count over data.
  always_comb begin
    led_n = '0;
    if (sw_0[SW_STAT])
      led_n = {ferr_flag, 1'b0, busy, rxd_sync};
    else if (sw_0[SW_CNT])
      led_n = sw_0[SW_NIB] ? byte_cnt[3:0] : byte_cnt[7:4];
    else
      led_n = sw_0[SW_NIB] ? last_byte[3:0] : last_byte[7:4];
  end

endmodule

// File: tb/tb_uart_impl_top.sv
// Self-checking bench for uart_impl_top with a short bit period.
module tb_uart_impl_top;

  localparam int unsigned CLK_HZ   = 1600000;
  localparam int unsigned BIT_RATE = 100000;
  localparam int unsigned CPB      = CLK_HZ / BIT_RATE;

  logic       clk = 1'b0;
  logic [3:0] sw_0;
  logic [3:0] led;
  logic       uart_rxd;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state
  logic [7:0] m_last;
  logic [7:0] m_cnt;
  logic       m_ferr;
  int         m_valid = 0;
  int         valid_seen = 0;

  typedef struct {
    logic [7:0] data;
    logic [3:0] exp_led;
  } vec_t;
  vec_t seq [15];

  uart_impl_top #(
    .BIT_RATE (BIT_RATE),
    .CLK_HZ   (CLK_HZ)
  ) dut (
    .clk      (clk),
    .sw_0     (sw_0),
    .led      (led),
    .uart_rxd (uart_rxd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.u_rx.rx_valid === 1'b1) valid_seen++;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: led=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_led(input logic [3:0] sw);
    if (sw[3]) return {m_ferr, 1'b0, 1'b0, 1'b1};
    else if (sw[2]) return sw[1] ? m_cnt[3:0] : m_cnt[7:4];
    else return sw[1] ? m_last[3:0] : m_last[7:4];
  endfunction

  task automatic model_reset();
    m_last = '0;
    m_cnt  = '0;
    m_ferr = 1'b0;
  endtask

  task automatic do_reset();
    sw_0 = 4'b0010;
    cycles(5);
    model_reset();
    sw_0 = 4'b0011;
    cycles(2);
  endtask

  // Drive one frame; line is left high at the end of the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      cycles(CPB);
    end
    uart_rxd = stop_bit;
    cycles(CPB);
    uart_rxd = 1'b1;
    if (stop_bit) begin
      m_last = b;
      m_cnt  = m_cnt + 8'd1;
      m_valid++;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic show(input logic [3:0] sw);
    sw_0 = sw;
    cycles(2);
  endtask

  initial begin
    logic [7:0] b;
    logic       good;
    logic [3:0] sw;
    int         gap;
    int         v0;

    seq[0]  = '{8'h41, 4'h1}; seq[1]  = '{8'h31, 4'h1};
    seq[2]  = '{8'h42, 4'h2}; seq[3]  = '{8'h32, 4'h2};
    seq[4]  = '{8'h43, 4'h3}; seq[5]  = '{8'h33, 4'h3};
    seq[6]  = '{8'h44, 4'h4}; seq[7]  = '{8'h34, 4'h4};
    seq[8]  = '{8'h00, 4'h0}; seq[9]  = '{8'h61, 4'h1};
    seq[10] = '{8'h62, 4'h2}; seq[11] = '{8'h63, 4'h3};
    seq[12] = '{8'h64, 4'h4}; seq[13] = '{8'h00, 4'h0};
    seq[14] = '{8'h00, 4'h0};

    uart_rxd = 1'b1;
    sw_0     = 4'b0010;
    model_reset();

    // Reset state
    cycles(5);
    check("reset_held", led, 4'h0);
    sw_0 = 4'b0011;
    cycles(2);
    check("reset_data", led, 4'h0);
    show(4'b0111);
    check("reset_count", led, 4'h0);
    show(4'b1011);
    check("reset_status", led, 4'h1);

    // Single byte, both nibbles
    show(4'b0011);
    send_frame(8'h41, 1'b1);
    cycles(2);
    check("A_low", led, 4'h1);
    show(4'b0001);
    check("A_high", led, 4'h4);

    // Back-to-back sequence, zero idle gap between frames
    do_reset();
    for (int i = 0; i < 15; i++) begin
      send_frame(seq[i].data, 1'b1);
      check($sformatf("seq%0d", i), led, seq[i].exp_led);
    end
    show(4'b0111);
    check("seq_count", led, 4'hF);
    show(4'b0101);
    check("seq_count_hi", led, 4'h0);

    // Framing error: byte discarded, sticky flag set
    show(4'b0011);
    v0 = valid_seen;
    send_frame(8'h5A, 1'b0);
    cycles(20);
    check("ferr_data", led, 4'h0);
    n_chk++;
    if (valid_seen != v0) begin
      n_err++;
      $display("FAIL ferr_valid: pulses=%0d expected=%0d", valid_seen - v0, 0);
    end
    show(4'b1011);
    check("ferr_status", led, 4'h9);

    // Short glitch shorter than half a bit
    uart_rxd = 1'b0;
    cycles(3);
    uart_rxd = 1'b1;
    cycles(20);
    check("glitch_status", led, exp_led(4'b1011));
    show(4'b0111);
    check("glitch_count", led, 4'hF);

    // Reset in the middle of bit 4
    show(4'b0011);
    uart_rxd = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = i[0];
      cycles(CPB);
    end
    uart_rxd = 1'b1;
    cycles(CPB / 2);
    sw_0 = 4'b0010;
    cycles(3);
    model_reset();
    check("midreset_held", led, 4'h0);
    sw_0 = 4'b0011;
    cycles(2 * CPB);
    check("midreset_data", led, 4'h0);
    show(4'b1011);
    check("midreset_status", led, 4'h1);
    show(4'b0011);
    send_frame(8'h37, 1'b1);
    cycles(2);
    check("after_reset_37", led, 4'h7);
    show(4'b0111);
    check("after_reset_cnt", led, 4'h1);

    // Randomized frames against the model
    for (int i = 0; i < 24; i++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      sw   = {3'($urandom), 1'b1};
      sw_0 = sw;
      send_frame(b, good);
      gap  = good ? int'($urandom_range(0, 6)) : 20 + int'($urandom_range(0, 10));
      cycles(gap);
      check($sformatf("rand%0d_b%02h_sw%h", i, b, sw), led, exp_led(sw));
    end

    // Count wrap 255 -> 0
    sw_0 = 4'b0011;
    for (int i = 0; i < 256 && m_cnt != 8'hFF; i++) send_frame(8'($urandom), 1'b1);
    show(4'b0111);
    check("cnt_ff_lo", led, 4'hF);
    show(4'b0101);
    check("cnt_ff_hi", led, 4'hF);
    send_frame(8'hC6, 1'b1);
    cycles(2);
    check("cnt_wrap_hi", led, 4'h0);
    show(4'b0111);
    check("cnt_wrap_lo", led, 4'h0);
    show(4'b0001);
    check("wrap_byte_hi", led, 4'hC);

    // Total valid pulses seen
    n_chk++;
    if (valid_seen != m_valid) begin
      n_err++;
      $display("FAIL valid_total: pulses=%0d expected=%0d", valid_seen, m_valid);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
